// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: memory read port, decoder handshake,
// jump request and the architectural PC.
interface fetch_sequencer_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [7:0]  mem_data;
  logic [23:0] instr;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic [15:0] jump_addr;
  logic [15:0] pc;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_ready,
    input  mem_data,
    output instr,
    output instr_len,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  jump,
    input  jump_addr,
    output pc
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_ready,
    output mem_data,
    input  instr,
    input  instr_len,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output jump,
    output jump_addr,
    input  pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: walks the PC over an 8-bit bus,
// assembles 1..3 byte instructions and holds each until the decoder takes it.
module fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input logic clk,
  input logic rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [23:0] instr_q, instr_d;
  logic [1:0]  len_q, len_d;
  logic [15:0] ipc_q, ipc_d;
  logic [1:0]  dec_len;

  always_comb begin
    dec_len = 2'd1;
    unique case (1'b1)
      (bus.mem_data[7:6] == 2'b11): dec_len = 2'd3;
      (bus.mem_data[7:6] == 2'b10): dec_len = 2'd2;
      default:                      dec_len = 2'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    len_d   = len_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      S_FETCH0: begin
        if (bus.mem_ready) begin
          instr_d = {16'h0000, bus.mem_data};
          len_d   = dec_len;
          ipc_d   = pc_q;
          pc_d    = pc_q + 16'd1;
          state_d = (dec_len == 2'd1) ? S_HOLD : S_FETCH1;
        end
      end
      S_FETCH1: begin
        if (bus.mem_ready) begin
          instr_d[15:8] = bus.mem_data;
          pc_d          = pc_q + 16'd1;
          state_d       = (len_q == 2'd2) ? S_HOLD : S_FETCH2;
        end
      end
      S_FETCH2: begin
        if (bus.mem_ready) begin
          instr_d[23:16] = bus.mem_data;
          pc_d           = pc_q + 16'd1;
          state_d        = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.instr_ready) begin
          state_d = S_FETCH0;
        end
      end
      default: state_d = S_FETCH0;
    endcase
    // a jump discards any byte landing this cycle and any partial instruction
    if (bus.jump) begin
      pc_d    = bus.jump_addr;
      state_d = S_FETCH0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH0;
      pc_q    <= RESET_VECTOR;
      instr_q <= 24'h0;
      len_q   <= 2'd0;
      ipc_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      len_q   <= len_d;
      ipc_q   <= ipc_d;
    end
  end

  assign bus.mem_rd      = (state_q != S_HOLD) && !rst;
  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = (state_q == S_HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_len   = len_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against a
// memory-image reference of instruction boundaries.
module tb_fetch_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] mem [0:65535];
  int   wait_cfg;
  int   wcnt;
  logic rand_mode;
  logic rnd_q;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_VECTOR(16'h0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_data  = mem[bus.mem_addr];
  assign bus.mem_ready = bus.mem_rd &&
                         (rand_mode ? rnd_q : (wcnt == wait_cfg));

  always @(posedge clk) begin
    rnd_q <= 1'($urandom_range(0, 1));
    if (bus.jump || !bus.mem_rd || bus.mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ref_len(logic [7:0] b0);
    if (b0 >= 8'hC0) return 3;
    if (b0 >= 8'h80) return 2;
    return 1;
  endfunction

  initial begin
    logic [15:0] exp_start;
    logic [15:0] off;
    logic [23:0] exp_instr;
    logic [23:0] held;
    int          elen;
    int          idle;

    checks    = 0;
    errors    = 0;
    wait_cfg  = 0;
    rand_mode = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0100] = 8'hC1; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
    mem[16'h0103] = 8'h00;
    mem[16'h0200] = 8'h80; mem[16'h0201] = 8'hAB;
    mem[16'h0202] = 8'hC5; mem[16'h0203] = 8'h11; mem[16'h0204] = 8'h22;
    mem[16'h4000] = 8'h05;
    mem[16'hFFFF] = 8'h85; mem[16'h0000] = 8'h77;

    rst = 1'b1;
    bus.jump = 1'b0;
    bus.jump_addr = 16'h0;
    bus.instr_ready = 1'b1;

    // reset
    tick();
    chk("rst_mem_rd0", bus.mem_rd, 0);
    chk("rst_valid0", bus.instr_valid, 0);
    tick();
    chk("rst_mem_rd1", bus.mem_rd, 0);
    chk("rst_valid1", bus.instr_valid, 0);
    chk("rst_pc", bus.pc, 32'h0100);
    chk("rst_instr", bus.instr, 0);
    chk("rst_len", bus.instr_len, 0);
    chk("rst_ipc", bus.instr_pc, 0);
    rst = 1'b0;
    #1;
    chk("rel_mem_rd", bus.mem_rd, 1);
    chk("rel_addr", bus.mem_addr, 32'h0100);

    // zero-wait 3-byte instruction
    tick();
    chk("z_c1_valid", bus.instr_valid, 0);
    chk("z_c1_addr", bus.mem_addr, 32'h0101);
    tick();
    chk("z_c2_valid", bus.instr_valid, 0);
    tick();
    chk("z_valid", bus.instr_valid, 1);
    chk("z_instr", bus.instr, 32'h1234C1);
    chk("z_len", bus.instr_len, 3);
    chk("z_ipc", bus.instr_pc, 32'h0100);
    chk("z_pc", bus.pc, 32'h0103);
    chk("z_hold_rd", bus.mem_rd, 0);
    tick();
    chk("z_next_rd", bus.mem_rd, 1);
    chk("z_next_addr", bus.mem_addr, 32'h0103);

    // jump away while waiting, then two wait states per byte
    wait_cfg = 2;
    bus.instr_ready = 1'b0;
    bus.jump = 1'b1;
    bus.jump_addr = 16'h0200;
    tick();
    bus.jump = 1'b0;
    chk("w_addr0", bus.mem_addr, 32'h0200);
    tick();
    chk("w_addr1", bus.mem_addr, 32'h0200);
    tick();
    chk("w_addr2", bus.mem_addr, 32'h0200);
    chk("w_rd2", bus.mem_rd, 1);
    tick();
    chk("w_addr3", bus.mem_addr, 32'h0201);
    tick();
    tick();
    chk("w_nohold", bus.instr_valid, 0);
    tick();
    chk("w_valid", bus.instr_valid, 1);
    chk("w_instr", bus.instr, 32'h00AB80);
    chk("w_len", bus.instr_len, 2);
    chk("w_ipc", bus.instr_pc, 32'h0200);
    chk("w_pc", bus.pc, 32'h0202);

    // backpressure
    held = bus.instr;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", bus.instr_valid, 1);
      chk("bp_instr", bus.instr, held);
      chk("bp_rd", bus.mem_rd, 0);
      chk("bp_pc", bus.pc, 32'h0202);
    end
    bus.instr_ready = 1'b1;
    wait_cfg = 0;
    tick();
    chk("bp_rel_rd", bus.mem_rd, 1);
    chk("bp_rel_addr", bus.mem_addr, 32'h0202);

    // jump in FETCH(1) coinciding with mem_ready
    tick();
    chk("j_f1_addr", bus.mem_addr, 32'h0203);
    chk("j_f1_ready", bus.mem_ready, 1);
    bus.jump = 1'b1;
    bus.jump_addr = 16'h4000;
    bus.instr_ready = 1'b0;
    tick();
    bus.jump = 1'b0;
    chk("j_valid", bus.instr_valid, 0);
    chk("j_addr", bus.mem_addr, 32'h4000);
    chk("j_rd", bus.mem_rd, 1);
    tick();
    chk("j_hold_valid", bus.instr_valid, 1);
    chk("j_hold_instr", bus.instr, 32'h000005);
    chk("j_hold_len", bus.instr_len, 1);
    chk("j_hold_pc", bus.pc, 32'h4001);

    // jump in HOLD without ready drops the instruction
    bus.jump = 1'b1;
    bus.jump_addr = 16'hFFFF;
    tick();
    bus.jump = 1'b0;
    chk("jh_valid", bus.instr_valid, 0);
    chk("jh_addr", bus.mem_addr, 32'hFFFF);

    // wrap
    tick();
    chk("wr_addr", bus.mem_addr, 32'h0000);
    tick();
    chk("wr_valid", bus.instr_valid, 1);
    chk("wr_instr", bus.instr, 32'h007785);
    chk("wr_len", bus.instr_len, 2);
    chk("wr_ipc", bus.instr_pc, 32'hFFFF);
    chk("wr_pc", bus.pc, 32'h0001);

    // jump together with acceptance
    bus.instr_ready = 1'b1;
    bus.jump = 1'b1;
    bus.jump_addr = 16'h0300;
    tick();
    bus.jump = 1'b0;
    chk("jr_valid", bus.instr_valid, 0);
    chk("jr_addr", bus.mem_addr, 32'h0300);

    // randomized: every delivered instruction must match the memory image
    rand_mode = 1'b1;
    exp_start = 16'h0300;
    idle = 0;
    for (int c = 0; c < 4000; c++) begin
      elen = ref_len(mem[exp_start]);
      chk("r_pc_addr", bus.mem_addr, bus.pc);
      chk("r_excl", 32'(bus.mem_rd ^ bus.instr_valid), 1);
      if (bus.mem_rd) begin
        off = bus.mem_addr - exp_start;
        chk("r_window", 32'(int'(off) < elen), 1);
      end
      if (bus.instr_valid) begin
        exp_instr = {mem[exp_start + 16'd2], mem[exp_start + 16'd1], mem[exp_start]};
        if (elen < 3) exp_instr[23:16] = 8'h00;
        if (elen < 2) exp_instr[15:8] = 8'h00;
        chk("r_instr", bus.instr, exp_instr);
        chk("r_len", bus.instr_len, elen);
        chk("r_ipc", bus.instr_pc, exp_start);
        chk("r_pc", bus.pc, 16'(exp_start + 16'(elen)));
      end
      bus.instr_ready = 1'($urandom_range(0, 1));
      bus.jump = ($urandom_range(0, 29) == 0);
      bus.jump_addr = 16'($urandom);
      if (bus.jump) begin
        exp_start = bus.jump_addr;
        idle = 0;
      end else if (bus.instr_valid && bus.instr_ready) begin
        exp_start = exp_start + 16'(elen);
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 200) begin
        chk("r_timeout", idle, 0);
        break;
      end
      tick();
      bus.jump = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the 16-bit program counter of the CPU through instruction-byte fetches from the 8-bit memory bus. It assembles variable-length instructions of 1 to 3 bytes and hands each one to the decoder over a valid/ready handshake. It is the single owner of PC increment and jump loads; the decoder never writes the PC directly.

## Interface
- RESET_VECTOR, 16'h0000, PC value loaded by reset

- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous reset, active-high
- jump  in  1  load PC from jump_addr; abort the current fetch
- jump_addr  in  16  jump target
- mem_addr  out  16  fetch address; equals pc
- mem_rd  out  1  read request
- mem_ready  in  1  memory returns mem_data this cycle
- mem_data  in  8  fetched byte
- instr  out  24  assembled instruction: byte0 [7:0], byte1 [15:8], byte2 [23:16]; unused bytes 0
- instr_len  out  2  instruction length, 1..3
- instr_pc  out  16  address of byte0 of instr
- instr_valid  out  1  instr/instr_len/instr_pc valid
- instr_ready  in  1  decoder accepts the instruction
- pc  out  16  current program counter

## Operation
- Clock is `clk`. Reset is synchronous and active-high on `rst`.
- Length decode uses byte0[7:6]:
  - 2'b11 → 3 bytes
  - 2'b10 → 2 bytes
  - otherwise → 1 byte
- FSM states:
  - FETCH(k), k = byte index 0..2, with target length len.
  - HOLD.
- Reset:
  - Registered values: pc=RESET_VECTOR, state=FETCH(0), instr=0, instr_len=0, instr_pc=0.
  - Outputs: instr_valid=0. mem_rd is forced 0 while rst=1.
- FETCH(k):
  - mem_rd=1, mem_addr=pc.
  - On mem_ready: store the byte at index k and set pc<=pc+1, with 16-bit wrap (FFFF→0000).
  - At k=0, additionally latch instr_pc<=pc, decode len, and clear bytes 1..2.
  - If k+1 == len, go to HOLD. Otherwise go to FETCH(k+1).
- HOLD:
  - mem_rd=0, instr_valid=1.
  - instr, instr_len and instr_pc stay stable until accepted.
  - On instr_ready, go to FETCH(0).
- jump has priority in every state:
  - pc<=jump_addr and state<=FETCH(0).
  - Any partially assembled bytes are discarded.
  - A byte arriving with mem_ready in the same cycle is discarded, and pc does not increment.
- jump together with instr_ready in HOLD: the handshake completes (the instruction is consumed) and the jump is applied.
- jump in HOLD without instr_ready: the held instruction is dropped and instr_valid=0 next cycle.
- rst has priority over jump.
- Outputs mem_rd, mem_addr and instr_valid are combinational decodes of the registered state and pc. No other combinational paths exist from inputs to outputs.

## Timing
- Memory handshake: mem_rd stays high until mem_ready. mem_addr is stable while mem_rd=1. Memory wait states are unbounded.
- Zero-wait memory: an N-byte instruction reaches instr_valid=1 N cycles after entering FETCH(0).
- HOLD lasts at least 1 cycle. Best-case throughput is one 1-byte instruction every 2 cycles, or one 3-byte instruction every 4 cycles.
- First mem_rd=1 occurs in the first cycle after rst deasserts.
- After jump: FETCH(0) at jump_addr begins the next cycle, and mem_addr=jump_addr in that cycle.
- pc always points to the next byte to fetch. Once in HOLD, pc = instr_pc + instr_len (mod 2^16).

## Test plan
- Reset, RESET_VECTOR=16'h0100: rst high 2 cycles → mem_rd=0 and instr_valid=0 during reset; mem_rd=1 with mem_addr=0100 on the first cycle after release.
- Zero-wait memory holding C1 34 12 at 0100, instr_ready=1 → instr_valid in cycle 3 with instr=123 4C1, instr_len=3, instr_pc=0100, pc=0103. Next fetch starts at 0103.
- Memory with 2 wait states per byte and a 2-byte opcode 80 at 0200 → mem_addr held at 0200 for 3 cycles, then 0201. Result instr=00xx80 with byte2 zero, instr_len=2, pc=0202.
- Backpressure: instr_ready=0 for 5 cycles in HOLD → instr stable, mem_rd=0, pc unchanged. instr_ready=1 → next cycle mem_rd=1.
- Jump to 4000 during FETCH(1) in the same cycle as mem_ready → byte discarded, no instr_valid, next cycle mem_addr=4000. Jump in HOLD with instr_ready=0 → instr_valid falls next cycle.
- Wrap: 2-byte instruction at FFFF → bytes fetched from FFFF then 0000, instr_pc=FFFF, pc=0001.
